mips_mc_controller: RTL and testbench

Multicycle control FSM for the MIPS core. It sequences the shared 32-bit ALU, register file, instruction register and unified memory port across the fetch, decode, execute, memory and writeback steps of each instruction. It drives the 4-bit ALU operation code directly and handles variable-latency memory through a ready handshake. It sits between the instruction register (op/funct) and the datapath muxes and enables.

---
 rtl/mips_mc_controller.sv | 208 ++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath muxes, enables and the 4-bit ALU opcode.
module mips_mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t state_q, state_d;
  // lw/sw choice is latched in DECODE so op may change before MEMADR.
  logic   is_sw_q, is_sw_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_sw_d    = is_sw_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_AND;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state      = state_q;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          pc_en    = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        is_sw_d   = (op == OP_SW);
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYP:        state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_ALUWB;
        case (funct)
          6'b100000: alu_op = ALU_ADD;
          6'b100010: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b101010: alu_op = ALU_SLT;
          6'b100111: alu_op = ALU_NOR;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        instr_done = 1'b1;
        pc_en      = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset blanks every output so nothing leaks out of an abandoned instruction.
    if (!rst_n) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = 4'b0000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      state      = 4'd0;
    end
  end
endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle expected output vectors are
// queued by the driver and checked by an independent negedge monitor.
module tb_mips_mc_controller;
  logic       clk, rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op, state;

  mips_mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  // Vector layout: pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg
  // reg_write alu_src_a alu_src_b[2] pc_src[2] alu_op[4] instr_done illegal state[4]
  localparam logic [22:0] E_ZERO   = 23'd0;
  localparam logic [22:0] E_FETCH  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0010,1'b0,1'b0,4'd0};
  localparam logic [22:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,4'b0010,1'b0,1'b0,4'd1};
  localparam logic [22:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010,1'b0,1'b0,4'd2};
  localparam logic [22:0] E_MEMRD  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,1'b0,4'd3};
  localparam logic [22:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b1,1'b0,4'd4};
  localparam logic [22:0] E_MEMWR  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,1'b0,4'd5};
  localparam logic [22:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,4'b0000,1'b0,1'b0,4'd6};
  localparam logic [22:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b1,1'b0,4'd7};
  localparam logic [22:0] E_BRANCH = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,4'b0110,1'b1,1'b0,4'd8};
  localparam logic [22:0] E_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010,1'b0,1'b0,4'd9};
  localparam logic [22:0] E_IWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b1,1'b0,4'd10};
  localparam logic [22:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,4'b0000,1'b1,1'b0,4'd11};
  localparam logic [22:0] M_PC_EN  = 23'h400000;
  localparam logic [22:0] M_IR_WR  = 23'h040000;
  localparam logic [22:0] M_DONE   = 23'h000020;
  localparam logic [22:0] M_ILL    = 23'h000010;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic [22:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle the controller presents its output vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] act, exp_v;
      string       t;
      act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, pc_src, alu_op, instr_done,
             illegal, state};
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s: got %06h want %06h (state got %0d want %0d)",
                 t, act, exp_v, act[3:0], exp_v[3:0]);
      end
    end
  end

  // Driver tasks
  task automatic step(input logic rst_v, input logic mr, input logic [5:0] op_v,
                      input logic [5:0] fn_v, input logic z,
                      input logic [22:0] exp_v, input string t);
    @(posedge clk);
    #1;
    rst_n     = rst_v;
    mem_ready = mr;
    op        = op_v;
    funct     = fn_v;
    zero      = z;
    exp_q.push_back(exp_v);
    tag_q.push_back(t);
  endtask

  task automatic fetch_decode(input logic [5:0] op_v, input logic [22:0] dec_exp,
                              input string t);
    step(1'b1, 1'b1, 6'b111111, 6'b0, 1'b0, E_FETCH | M_PC_EN | M_IR_WR, {t, "_fetch"});
    step(1'b1, 1'b0, op_v, 6'b0, 1'b0, dec_exp, {t, "_decode"});
  endtask

  task automatic rtype(input logic [5:0] fn_v, input logic [3:0] exp_op, input string t);
    logic [22:0] e;
    e = E_EXEC;
    e[9:6] = exp_op;
    fetch_decode(OP_R, E_DECODE, t);
    step(1'b1, 1'b0, OP_R, fn_v, 1'b0, e, {t, "_exec"});
    step(1'b1, 1'b1, 6'b111111, 6'b0, 1'b0, E_ALUWB, {t, "_aluwb"});
  endtask

  task automatic branch(input logic [5:0] op_v, input logic z, input logic [22:0] e,
                        input string t);
    fetch_decode(op_v, E_DECODE, t);
    step(1'b1, 1'b0, op_v, 6'b0, z, e, {t, "_branch"});
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;
    // Reset held three cycles, then idle fetch waiting on memory
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'b0, 6'b0, 1'b0, E_ZERO, "reset");
    step(1'b1, 1'b0, 6'b0, 6'b0, 1'b0, E_FETCH, "idle_fetch0");
    step(1'b1, 1'b0, 6'b0, 6'b0, 1'b0, E_FETCH, "idle_fetch1");
    step(1'b1, 1'b1, 6'b0, 6'b0, 1'b0, E_FETCH | M_PC_EN | M_IR_WR, "idle_fetch_rdy");
    // Decoded as j to return to FETCH
    step(1'b1, 1'b0, OP_J, 6'b0, 1'b0, E_DECODE, "idle_decode");
    step(1'b1, 1'b1, OP_J, 6'b0, 1'b0, E_JUMP, "idle_jump");

    // lw, op changed after DECODE must not redirect to MEMWR
    fetch_decode(OP_LW, E_DECODE, "lw");
    step(1'b1, 1'b0, OP_SW, 6'b0, 1'b0, E_MEMADR, "lw_memadr");
    step(1'b1, 1'b1, OP_SW, 6'b0, 1'b0, E_MEMRD, "lw_memrd");
    step(1'b1, 1'b0, OP_SW, 6'b0, 1'b0, E_MEMWB, "lw_memwb");

    // sw with two wait cycles
    fetch_decode(OP_SW, E_DECODE, "sw");
    step(1'b1, 1'b1, OP_SW, 6'b0, 1'b0, E_MEMADR, "sw_memadr");
    step(1'b1, 1'b0, OP_SW, 6'b0, 1'b0, E_MEMWR, "sw_wait0");
    step(1'b1, 1'b0, OP_SW, 6'b0, 1'b0, E_MEMWR, "sw_wait1");
    step(1'b1, 1'b1, OP_SW, 6'b0, 1'b0, E_MEMWR | M_DONE, "sw_done");

    // R-type sweep
    rtype(6'b100000, 4'b0010, "r_add");
    rtype(6'b100010, 4'b0110, "r_sub");
    rtype(6'b100100, 4'b0000, "r_and");
    rtype(6'b100101, 4'b0001, "r_or");
    rtype(6'b101010, 4'b0111, "r_slt");
    rtype(6'b100111, 4'b1100, "r_nor");
    fetch_decode(OP_R, E_DECODE, "r_bad");
    step(1'b1, 1'b1, OP_R, 6'b000000, 1'b0, E_EXEC | M_ILL, "r_bad_exec");

    // addi
    fetch_decode(OP_ADDI, E_DECODE, "addi");
    step(1'b1, 1'b0, OP_ADDI, 6'b0, 1'b0, E_ADDIEX, "addi_ex");
    step(1'b1, 1'b0, OP_ADDI, 6'b0, 1'b0, E_IWB, "addi_wb");

    // Branches
    branch(OP_BEQ, 1'b1, E_BRANCH | M_PC_EN, "beq_taken");
    branch(OP_BEQ, 1'b0, E_BRANCH, "beq_not");
    branch(OP_BNE, 1'b0, E_BRANCH | M_PC_EN, "bne_taken");
    branch(OP_BNE, 1'b1, E_BRANCH, "bne_not");

    // Illegal op
    fetch_decode(6'b111111, E_DECODE | M_ILL, "illegal_op");

    // Abort during MEMRD wait
    fetch_decode(OP_LW, E_DECODE, "abort");
    step(1'b1, 1'b0, OP_LW, 6'b0, 1'b0, E_MEMADR, "abort_memadr");
    step(1'b1, 1'b0, OP_LW, 6'b0, 1'b0, E_MEMRD, "abort_memrd");
    step(1'b0, 1'b1, OP_LW, 6'b0, 1'b0, E_ZERO, "abort_rst");
    step(1'b1, 1'b0, OP_LW, 6'b0, 1'b0, E_FETCH, "abort_fetch");
    step(1'b1, 1'b0, OP_LW, 6'b0, 1'b0, E_FETCH, "abort_fetch_hold");

    // Drain with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
